// File: rtl/uart_tx_32bit.sv
// 32-bit word to four 8N1 UART bytes, MSB first, with a valid/ready input handshake.
// All outputs are registered so the serial line is glitch-free.
module uart_tx_32bit #(
  parameter int CLKS_PER_BIT = 625,
  parameter int GAP_CLKS     = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_data,
  input  logic        i_datavalid,
  output logic        o_ready,
  output logic        o_uart_tx,
  output logic [7:0]  o_txbyte,
  output logic        o_txdone,
  output logic        o_busy,
  output logic [31:0] o_count
);

  localparam int CW = $clog2(CLKS_PER_BIT + GAP_CLKS) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

  // NEXT is never registered: the byte-advance decision happens in the last STOP/GAP cycle.
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, NEXT} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [31:0] shiftWord_q, shiftWord_d;
  logic [7:0]  txByte_q, txByte_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [31:0] count_q, count_d;
  logic        byteEnd;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      clkCnt_q    <= '0;
      bitIdx_q    <= '0;
      byteIdx_q   <= '0;
      shiftWord_q <= '0;
      txByte_q    <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      clkCnt_q    <= clkCnt_d;
      bitIdx_q    <= bitIdx_d;
      byteIdx_q   <= byteIdx_d;
      shiftWord_q <= shiftWord_d;
      txByte_q    <= txByte_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clkCnt_d    = clkCnt_q;
    bitIdx_d    = bitIdx_q;
    byteIdx_d   = byteIdx_q;
    shiftWord_d = shiftWord_q;
    txByte_d    = txByte_q;
    tx_d        = tx_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    count_d     = count_q;
    byteEnd     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        if (i_datavalid && ready_q) begin
          shiftWord_d = i_data;
          txByte_d    = i_data[31:24];
          byteIdx_d   = 2'd0;
          clkCnt_d    = '0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          bitIdx_d = 3'd0;
          tx_d     = txByte_q[0];
          state_d  = DATA;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end

      DATA: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          if (bitIdx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = txByte_q[bitIdx_d];
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          if (GAP_CLKS > 0) begin
            state_d = GAP;
          end else begin
            byteEnd = 1'b1;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end

      GAP: begin
        tx_d = 1'b1;
        if (clkCnt_q == GAP_LAST) begin
          clkCnt_d = '0;
          byteEnd  = 1'b1;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // The shift word moves left a byte at a time so the next byte is always at [23:16].
    if (byteEnd) begin
      if (byteIdx_q != 2'd3) begin
        byteIdx_d   = byteIdx_q + 2'd1;
        shiftWord_d = {shiftWord_q[23:0], 8'h00};
        txByte_d    = shiftWord_q[23:16];
        tx_d        = 1'b0;
        state_d     = START;
      end else begin
        done_d  = 1'b1;
        count_d = count_q + 32'd1;
        ready_d = 1'b1;
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign o_ready   = ready_q;
  assign o_uart_tx = tx_q;
  assign o_txbyte  = txByte_q;
  assign o_txdone  = done_q;
  assign o_busy    = busy_q;
  assign o_count   = count_q;

endmodule

// File: tb/tb_uart_tx_32bit.sv
// Directed bench for uart_tx_32bit: one instance with no inter-byte gap, one with GAP_CLKS=3.
module tb_uart_tx_32bit;

  localparam int CPB    = 4;
  localparam int GAP2   = 3;
  localparam int FRAME1 = 4 * (10 * CPB);
  localparam int FRAME2 = 4 * (10 * CPB + GAP2);

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data1 = '0, data2 = '0;
  logic        valid1 = 1'b0, valid2 = 1'b0;
  logic        ready1, tx1, done1, busy1;
  logic        ready2, tx2, done2, busy2;
  logic [7:0]  byte1, byte2;
  logic [31:0] count1, count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_32bit #(.CLKS_PER_BIT(CPB), .GAP_CLKS(0)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_data(data1), .i_datavalid(valid1),
    .o_ready(ready1), .o_uart_tx(tx1), .o_txbyte(byte1), .o_txdone(done1),
    .o_busy(busy1), .o_count(count1)
  );

  uart_tx_32bit #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP2)) dutGap (
    .i_clk(clk), .i_rstn(rstn), .i_data(data2), .i_datavalid(valid2),
    .o_ready(ready2), .o_uart_tx(tx2), .o_txbyte(byte2), .o_txdone(done2),
    .o_busy(busy2), .o_count(count2)
  );

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    rstn = 1'b0;
    repeat (n) stepCycle();
    rstn = 1'b1;
  endtask

  // Drives one handshake on the gap-free instance; returns in the first start-bit cycle.
  task automatic applyStimulus(input logic [31:0] w, input logic hold);
    data1  = w;
    valid1 = 1'b1;
    stepCycle();
    valid1 = hold;
  endtask

  // Expected line level k cycles after the first start-bit cycle of a word.
  function automatic logic expLine(input logic [31:0] w, input int k, input int cpb, input int gap);
    int len, b, r, pos;
    logic [31:0] sh;
    logic [7:0] byteVal;
    len = 10 * cpb + gap;
    b   = k / len;
    r   = k % len;
    sh  = w >> (8 * (3 - b));
    byteVal = sh[7:0];
    if (r >= 10 * cpb) return 1'b1;
    pos = r / cpb;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byteVal[pos-1];
  endfunction

  function automatic logic [7:0] expByte(input logic [31:0] w, input int b);
    logic [31:0] sh;
    sh = w >> (8 * (3 - b));
    return sh[7:0];
  endfunction

  task automatic test_reset();
    int errs;
    valid1 = 1'b0;
    valid2 = 1'b0;
    doReset(2);
    checks++;
    if ({tx1, ready1, busy1, done1} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected %b", {tx1, ready1, busy1, done1}, 4'b1000);
    end
    checks++;
    if ({byte1, count1} !== 40'h0) begin
      failures++;
      $display("[TB] FAIL reset_regs: got %h expected %h", {byte1, count1}, 40'h0);
    end
    checks++;
    if ({tx2, ready2, busy2, done2, byte2, count2} !== {4'b1000, 40'h0}) begin
      failures++;
      $display("[TB] FAIL reset_gap_dut: got %h expected %h", {tx2, ready2, busy2, done2, byte2, count2}, {4'b1000, 40'h0});
    end
    stepCycle();
    checks++;
    if (ready1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_ready: got %b expected 1", ready1);
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx1 !== 1'b1 || ready1 !== 1'b1 || count1 !== 32'd0 || done1 !== 1'b0 || busy1 !== 1'b0) errs++;
      stepCycle();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL idle_20: bad cycles %0d expected 0", errs);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [9:0] firstByte;
    int errs, doneErr, byteErr, stateErr;
    w = 32'hA1B2C3D4;
    firstByte = '0;
    errs = 0; doneErr = 0; byteErr = 0; stateErr = 0;
    applyStimulus(w, 1'b0);
    for (int k = 0; k < FRAME1; k++) begin
      if (tx1 !== expLine(w, k, CPB, 0)) errs++;
      if (done1 !== 1'b0) doneErr++;
      if (ready1 !== 1'b0 || busy1 !== 1'b1) stateErr++;
      if ((k % 40) == 0 && byte1 !== expByte(w, k / 40)) byteErr++;
      if (k < 40 && (k % 4) == 2) firstByte = {firstByte[8:0], tx1};
      stepCycle();
    end
    checks++;
    if (firstByte !== 10'b0100001011) begin
      failures++;
      $display("[TB] FAIL byte_A1: got %b expected %b", firstByte, 10'b0100001011);
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL word_line: bad cycles %0d expected 0", errs);
    end
    checks++;
    if (doneErr != 0 || stateErr != 0 || byteErr != 0) begin
      failures++;
      $display("[TB] FAIL word_status: done %0d state %0d txbyte %0d expected 0 0 0", doneErr, stateErr, byteErr);
    end
    checks++;
    if ({done1, ready1, busy1, tx1} !== 4'b1111 || count1 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL word_done: got %b cnt %0d expected 1111 cnt 1", {done1, ready1, busy1, tx1}, count1);
    end
    stepCycle();
    checks++;
    if ({done1, busy1} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL done_pulse: got %b expected 00", {done1, busy1});
    end
  endtask

  task automatic test_back_to_back();
    int errs, doneErr;
    logic idleBit, startBit;
    logic [31:0] cnt160;
    doReset(2);
    stepCycle();
    errs = 0; doneErr = 0;
    idleBit = 1'b0; startBit = 1'b1; cnt160 = '0;
    applyStimulus(32'h00000000, 1'b1);
    data1 = 32'hFFFFFFFF;
    for (int k = 0; k <= 2 * FRAME1 + 1; k++) begin
      if (k < FRAME1) begin
        if (tx1 !== expLine(32'h00000000, k, CPB, 0)) errs++;
      end else if (k > FRAME1 && k <= 2 * FRAME1) begin
        if (tx1 !== expLine(32'hFFFFFFFF, k - FRAME1 - 1, CPB, 0)) errs++;
      end
      if (done1 !== ((k == FRAME1) || (k == 2 * FRAME1 + 1))) doneErr++;
      if (k == FRAME1) begin
        idleBit = tx1;
        cnt160 = count1;
      end
      if (k == FRAME1 + 1) begin
        startBit = tx1;
        valid1 = 1'b0;
      end
      stepCycle();
    end
    checks++;
    if ({idleBit, startBit} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got %b expected 10", {idleBit, startBit});
    end
    checks++;
    if (errs != 0 || doneErr != 0) begin
      failures++;
      $display("[TB] FAIL b2b_line: bad line %0d bad done %0d expected 0 0", errs, doneErr);
    end
    checks++;
    if (cnt160 !== 32'd1 || count1 !== 32'd2) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d,%0d expected 1,2", cnt160, count1);
    end
    checks++;
    if ({busy1, tx1, ready1} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL b2b_after: got %b expected 011", {busy1, tx1, ready1});
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] w;
    int errs, readyErr, idleErr;
    w = 32'h5A3C0F96;
    errs = 0; readyErr = 0; idleErr = 0;
    applyStimulus(w, 1'b0);
    for (int k = 0; k < FRAME1; k++) begin
      if (tx1 !== expLine(w, k, CPB, 0)) errs++;
      if (ready1 !== 1'b0) readyErr++;
      if (k == 50) begin
        valid1 = 1'b1;
        data1  = 32'h11111111;
      end
      if (k == 53) valid1 = 1'b0;
      stepCycle();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL busy_line: bad cycles %0d expected 0", errs);
    end
    checks++;
    if (readyErr != 0) begin
      failures++;
      $display("[TB] FAIL busy_ready: high cycles %0d expected 0", readyErr);
    end
    checks++;
    if (done1 !== 1'b1 || count1 !== 32'd3) begin
      failures++;
      $display("[TB] FAIL busy_done: got %b cnt %0d expected 1 cnt 3", done1, count1);
    end
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      if (tx1 !== 1'b1 || busy1 !== 1'b0) idleErr++;
    end
    checks++;
    if (idleErr != 0) begin
      failures++;
      $display("[TB] FAIL busy_no_resend: bad cycles %0d expected 0", idleErr);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] w;
    int errs, holdErr, doneErr;
    w = 32'h89AB0055;
    errs = 0; holdErr = 0; doneErr = 0;
    applyStimulus(w, 1'b0);
    for (int k = 0; k <= 90; k++) begin
      if (tx1 !== expLine(w, k, CPB, 0)) errs++;
      stepCycle();
      if (k == 89) rstn = 1'b0;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("[TB] FAIL rst_pre_line: bad cycles %0d expected 0", errs);
    end
    checks++;
    if ({tx1, ready1, busy1, done1, byte1, count1} !== {4'b1000, 40'h0}) begin
      failures++;
      $display("[TB] FAIL rst_mid: got %h expected %h", {tx1, ready1, busy1, done1, byte1, count1}, {4'b1000, 40'h0});
    end
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      if (ready1 !== 1'b0 || tx1 !== 1'b1) holdErr++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      if (ready1 !== 1'b1 || tx1 !== 1'b1 || busy1 !== 1'b0) holdErr++;
    end
    checks++;
    if (holdErr != 0) begin
      failures++;
      $display("[TB] FAIL rst_hold: bad cycles %0d expected 0", holdErr);
    end
    w = 32'h0F1E2D3C;
    errs = 0;
    applyStimulus(w, 1'b0);
    for (int k = 0; k < FRAME1; k++) begin
      if (tx1 !== expLine(w, k, CPB, 0)) errs++;
      if (done1 !== 1'b0) doneErr++;
      stepCycle();
    end
    checks++;
    if (errs != 0 || doneErr != 0) begin
      failures++;
      $display("[TB] FAIL rst_new_word: bad line %0d bad done %0d expected 0 0", errs, doneErr);
    end
    checks++;
    if (done1 !== 1'b1 || count1 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL rst_new_done: got %b cnt %0d expected 1 cnt 1", done1, count1);
    end
  endtask

  task automatic test_gap();
    logic [31:0] w;
    logic [3:0] gapVec;
    int errs, doneErr, byteErr;
    w = 32'h12345678;
    errs = 0; doneErr = 0; byteErr = 0;
    gapVec = '0;
    checks++;
    if (ready2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gap_ready: got %b expected 1", ready2);
    end
    data2  = w;
    valid2 = 1'b1;
    stepCycle();
    valid2 = 1'b0;
    for (int k = 0; k < FRAME2; k++) begin
      if (tx2 !== expLine(w, k, CPB, GAP2)) errs++;
      if (done2 !== 1'b0) doneErr++;
      if ((k % 43) == 0 && byte2 !== expByte(w, k / 43)) byteErr++;
      if (k >= 40 && k <= 43) gapVec = {gapVec[2:0], tx2};
      stepCycle();
    end
    checks++;
    if (gapVec !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL gap_cycles: got %b expected 1110", gapVec);
    end
    checks++;
    if (errs != 0 || doneErr != 0 || byteErr != 0) begin
      failures++;
      $display("[TB] FAIL gap_frame: line %0d done %0d txbyte %0d expected 0 0 0", errs, doneErr, byteErr);
    end
    checks++;
    if (done2 !== 1'b1 || count2 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL gap_done: got %b cnt %0d expected 1 cnt 1", done2, count2);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
